// File: rtl/fetch_issue_ctrl_if.sv
// Fetch/issue bus: imem address/data, IF/ID instruction, PC, and branch resolve from MEM.
// The master side is the sequencer; the slave side is the surrounding pipeline/ROM.
interface fetch_issue_ctrl_if #(
    parameter int AW = 7
);
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic [31:0]   instr_out;
    logic [63:0]   pc;
    logic          branch_taken;
    logic [63:0]   branch_target;
    logic          stall;
    logic          br_bubble;

    modport master (
        output imem_addr, instr_out, pc, stall, br_bubble,
        input  imem_q, branch_taken, branch_target
    );
    modport slave (
        input  imem_addr, instr_out, pc, stall, br_bubble,
        output imem_q, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_issue_ctrl.sv
// LEGv8 fetch/issue sequencer: owns the PC, inserts NOP bubbles for RAW hazards
// and holds fetch for three cycles after a CBZ until MEM resolves it.
module fetch_issue_ctrl #(
    parameter int          AW  = 7,
    parameter logic [31:0] NOP = 32'h8b1f03ff
) (
    input  logic               clk,
    input  logic               reset,
    fetch_issue_ctrl_if.master bus
);
    typedef enum logic [1:0] {RUN, BW1, BW2, BW3} st_t;

    typedef struct packed {
        logic [4:0] s0;
        logic [4:0] s1;
        logic [4:0] dst;
        logic       br;
    } dec_t;

    localparam logic [4:0] XZR = 5'd31;

    st_t         st;
    logic [63:0] pc_r;
    logic [4:0]  d1, d2;
    dec_t        dec;
    logic        hazard;
    logic        unused_q;

    // Shift amount / address offset fields never name a register.
    assign unused_q = ^bus.imem_q[15:10];

    always_comb begin
        logic [31:0] q;
        q       = bus.imem_q;
        dec.s0  = XZR;
        dec.s1  = XZR;
        dec.dst = XZR;
        dec.br  = 1'b0;
        if (q[31:21] inside {11'h458, 11'h658, 11'h450, 11'h550}) begin
            dec.s0  = q[9:5];
            dec.s1  = q[20:16];
            dec.dst = q[4:0];
        end else if (q[31:22] == 10'b1101001101) begin
            dec.s0  = q[9:5];
            dec.dst = q[4:0];
        end else if (q[31:21] == 11'h7c2) begin
            dec.s0  = q[9:5];
            dec.dst = q[4:0];
        end else if (q[31:21] == 11'h7c0) begin
            dec.s0  = q[9:5];
            dec.s1  = q[4:0];
        end else if (q[31:24] == 8'hb4) begin
            dec.s0  = q[4:0];
            dec.br  = 1'b1;
        end
    end

    function automatic logic hit(input logic [4:0] s, input logic [4:0] a, input logic [4:0] b);
        return (s != XZR) && (s == a || s == b);
    endfunction

    assign hazard = (st == RUN) && (hit(dec.s0, d1, d2) || hit(dec.s1, d1, d2));

    always_comb begin
        bus.instr_out = NOP;
        bus.stall     = 1'b0;
        bus.br_bubble = 1'b0;
        if (!reset) begin
            if (st == RUN) begin
                if (hazard) bus.stall     = 1'b1;
                else        bus.instr_out = bus.imem_q;
            end else begin
                bus.br_bubble = 1'b1;
            end
        end
    end

    assign bus.pc        = pc_r;
    assign bus.imem_addr = pc_r[AW+1:2];

    // History shifts every cycle; anything other than an issued producer records XZR.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= '0;
            st   <= RUN;
            d1   <= XZR;
            d2   <= XZR;
        end else begin
            d2 <= d1;
            d1 <= XZR;
            case (st)
                RUN: if (!hazard) begin
                    pc_r <= pc_r + 64'd4;
                    d1   <= dec.dst;
                    if (dec.br) st <= BW1;
                end
                BW1: st <= BW2;
                BW2: st <= BW3;
                BW3: begin
                    if (bus.branch_taken) pc_r <= bus.branch_target;
                    st <= RUN;
                end
                default: st <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Randomized + directed bench for fetch_issue_ctrl against a timestamp-based
// issue model (last-write cycle per register, fetch-resume cycle after CBZ).
module tb_fetch_issue_ctrl;
    localparam logic [31:0] NOP = 32'h8b1f03ff;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_issue_ctrl_if #(.AW(7)) bus();
    fetch_issue_ctrl #(.AW(7), .NOP(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [31:0] rom [128];
    assign bus.imem_q = rom[bus.imem_addr];

    int n_chk = 0;
    int n_pass = 0;

    // model state
    logic [63:0] m_pc;
    int          m_cyc;
    int          lw [32];
    int          resume;

    // last observed outputs
    logic [63:0] o_pc;
    logic [6:0]  o_addr;
    logic [31:0] o_instr;
    logic        o_stall, o_bub;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic void tdec(input logic [31:0] w, output logic [4:0] a,
                                 output logic [4:0] b, output logic [4:0] d, output logic br);
        a = 31; b = 31; d = 31; br = 1'b0;
        casez (w[31:21])
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: begin a = w[9:5]; b = w[20:16]; d = w[4:0]; end
            11'b1101001101?:                  begin a = w[9:5]; d = w[4:0]; end
            11'b11111000010:                  begin a = w[9:5]; d = w[4:0]; end
            11'b11111000000:                  begin a = w[9:5]; b = w[4:0]; end
            11'b10110100???:                  begin a = w[4:0]; br = 1'b1; end
            default: ;
        endcase
    endfunction

    task automatic step(input logic r, input logic bt, input logic [63:0] tgt);
        logic [31:0] w, e_instr;
        logic        e_stall, e_bub, br, haz;
        logic [4:0]  a, b, d;
        logic [63:0] npc;
        @(posedge clk);
        #1;
        reset = r;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        @(negedge clk);
        o_pc = bus.pc; o_addr = bus.imem_addr; o_instr = bus.instr_out;
        o_stall = bus.stall; o_bub = bus.br_bubble;
        e_instr = NOP; e_stall = 1'b0; e_bub = 1'b0;
        if (r) begin
            chk("rst_instr", o_instr, e_instr);
            chk("rst_stall", o_stall, e_stall);
            chk("rst_bub", o_bub, e_bub);
            m_pc = 0; m_cyc = 0; resume = 0;
            for (int i = 0; i < 32; i++) lw[i] = -10;
        end else begin
            w   = rom[m_pc[8:2]];
            npc = m_pc;
            if (m_cyc < resume) begin
                e_bub = 1'b1;
                if (m_cyc == resume - 1 && bt) npc = tgt;
            end else begin
                tdec(w, a, b, d, br);
                haz = (a != 31 && m_cyc - lw[a] < 3) || (b != 31 && m_cyc - lw[b] < 3);
                if (haz) e_stall = 1'b1;
                else begin
                    e_instr = w;
                    npc = m_pc + 64'd4;
                    if (d != 31) lw[d] = m_cyc;
                    if (br) resume = m_cyc + 4;
                end
            end
            chk("pc", o_pc, m_pc);
            chk("addr", {57'd0, o_addr}, {57'd0, m_pc[8:2]});
            chk("instr", o_instr, e_instr);
            chk("stall", o_stall, e_stall);
            chk("bub", o_bub, e_bub);
            m_pc = npc;
            m_cyc++;
        end
    endtask

    task automatic fill_nop;
        for (int i = 0; i < 128; i++) rom[i] = NOP;
    endtask

    task automatic do_reset;
        step(1'b1, 1'b0, 64'd0);
        step(1'b1, 1'b0, 64'd0);
    endtask

    function automatic logic [4:0] rr();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
    endfunction

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 9))
            0: return {11'h458, rr(), 6'd0, rr(), rr()};
            1: return {11'h658, rr(), 6'd0, rr(), rr()};
            2: return {11'h450, rr(), 6'd0, rr(), rr()};
            3: return {11'h550, rr(), 6'd0, rr(), rr()};
            4: return {10'b1101001101, 1'($urandom), 5'd0, 6'($urandom), rr(), rr()};
            5: return {11'h7c2, 9'($urandom), 2'b00, rr(), rr()};
            6: return {11'h7c0, 9'($urandom), 2'b00, rr(), rr()};
            7: return {8'hb4, 19'($urandom), rr()};
            8: return NOP;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int nst;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 64'd0;
        fill_nop();

        // reset state
        do_reset();
        chk("reset_pc", o_pc, 64'd0);
        chk("reset_addr", {57'd0, o_addr}, 64'd0);

        // RAW distance 1
        rom[0] = 32'h8b050083; rom[1] = 32'hf8018003;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'd0);
        chk("raw1_issue", o_instr, 64'hf8018003);

        // RAW distance 2
        fill_nop();
        rom[0] = 32'h8b050083; rom[1] = 32'hf8000001; rom[2] = 32'hf8018003;
        do_reset();
        nst = 0;
        for (int i = 0; i < 5; i++) begin step(1'b0, 1'b0, 64'd0); nst += int'(o_stall); end
        chk("raw2_bubbles", 64'(nst), 64'd1);

        // XZR never hazards
        fill_nop();
        do_reset();
        nst = 0;
        for (int i = 0; i < 8; i++) begin step(1'b0, 1'b0, 64'd0); nst += int'(o_stall); end
        chk("xzr_bubbles", 64'(nst), 64'd0);

        // CBZ not taken
        rom[0] = 32'hb40000a0;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 64'd0);
        chk("cbz_nt_pc", o_pc, 64'd4);
        chk("cbz_nt_addr", {57'd0, o_addr}, 64'd1);

        // CBZ taken, early pulse ignored
        do_reset();
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 64'd100);
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 64'd20);
        step(1'b0, 1'b0, 64'd0);
        chk("cbz_t_pc", o_pc, 64'd20);
        chk("cbz_t_addr", {57'd0, o_addr}, 64'd5);

        // reset in BW2 aborts the wait, then walk to the wrap point
        do_reset();
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 64'd100);
        rom[0] = NOP;
        step(1'b1, 1'b1, 64'd100);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 64'd100);
        chk("abort_pc", o_pc, 64'd12);
        for (int i = 4; i < 128; i++) step(1'b0, 1'b1, 64'd100);
        chk("wrap_pc508", o_pc, 64'd508);
        step(1'b0, 1'b0, 64'd0);
        chk("wrap_pc512", o_pc, 64'd512);
        chk("wrap_addr", {57'd0, o_addr}, 64'd0);

        // random programs with noise on branch inputs and occasional resets
        for (int i = 0; i < 128; i++) rom[i] = rand_instr();
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) == 0, 1'($urandom), {32'($urandom), 32'($urandom)});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
